serial_slave_port_p: RTL and testbench

- Parametrised next-generation slave port for the bit-serial bus.
- Deserialises address, burst header and write data; drives a simple memory-side strobe interface; serialises read data back to the master.
- Performs split transactions for slow slaves and at burst boundaries, with generic widths, split granularity and delay threshold.
- Sits between the bus arbiter/master path and one slave memory.

---
 rtl/serial_slave_pkg.sv | 25 ++
 rtl/serial_shifter_p.sv | 48 ++++
 rtl/serial_slave_port_p.sv | 178 +++++++++++++++++
 tb/tb_serial_slave_port_p.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_slave_pkg.sv
// Shared types and elaboration helpers for the bit-serial slave port.
package serial_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WDATA,
    ST_WRITE,
    ST_RD_REQ,
    ST_RD_CAP,
    ST_SPLIT,
    ST_TX
  } state_t;

  // The header carries one address bit per cycle.
  function automatic int hdr_len(input int addr_w);
    return addr_w;
  endfunction

  // The burst field must fit inside the header window.
  function automatic bit burst_fits(input int addr_w, input int burst_w);
    return (burst_w + 1) <= addr_w;
  endfunction

endpackage

// File: rtl/serial_shifter_p.sv
// LSB-first shift register with a bit counter; shifts are ignored once full
// unless i_clear restarts the count in the same cycle.
module serial_shifter_p #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_data,
  output logic [W-1:0] o_data_next,
  output logic         o_bit,
  output logic         o_last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_base;
  logic          w_shift_ok;
  logic [W:0]    w_cat;

  assign w_cnt_base  = i_clear ? '0 : r_cnt;
  assign w_shift_ok  = i_shift && (w_cnt_base != CW'(W));
  assign w_cat       = {i_bit, r_data};
  assign o_data_next = w_shift_ok ? w_cat[W:1] : r_data;
  assign o_last      = w_shift_ok && (w_cnt_base == CW'(W - 1));
  assign o_data      = r_data;
  assign o_bit       = r_data[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= '0;
    end else begin
      r_data <= o_data_next;
      r_cnt  <= w_shift_ok ? w_cnt_base + CW'(1) : w_cnt_base;
    end
  end

endmodule

// File: rtl/serial_slave_port_p.sv
// Bit-serial bus slave port: deserialises header and write beats, strobes one
// memory, serialises read beats back, and splits for slow slaves and bursts.
module serial_slave_port_p
  import serial_slave_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int BURST_W      = 8,
  parameter int DELAY_W      = 6,
  parameter int SPLIT_THRESH = 5,
  parameter int SPLIT_BEATS  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DELAY_W-1:0] slave_delay,
  input  logic               read_enable,
  input  logic               write_enable,
  input  logic               m_valid,
  input  logic               m_ready,
  input  logic               rx_address,
  input  logic               rx_burst,
  input  logic               rx_data,
  output logic               s_ready,
  output logic               s_valid,
  output logic               tx_data,
  output logic               split_enable,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_wr,
  output logic               mem_rd,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam int HDR_LEN = hdr_len(ADDR_W);
  localparam int BW1     = BURST_W + 1;
  localparam logic [BW1-1:0]     SPLIT_C  = BW1'(SPLIT_BEATS);
  localparam logic [DELAY_W-1:0] THRESH_C = DELAY_W'(SPLIT_THRESH);

  generate
    if (!burst_fits(ADDR_W, BURST_W)) begin : g_bad_params
      $error("serial_slave_port_p: BURST_W+1 must not exceed ADDR_W");
    end
  endgenerate

  state_t               r_state, w_state_next;
  logic                 r_is_read;
  logic [ADDR_W-1:0]    r_addr;
  logic [BW1-1:0]       r_beat_cnt;
  logic [DELAY_W-1:0]   r_split_cnt;

  logic w_run, w_start, w_hdr_shift, w_wd_shift, w_tx_shift;
  logic w_addr_last, w_data_last, w_tx_last, w_tx_bit;
  logic [HDR_LEN-1:0] w_addr_data, w_addr_next;
  logic [BW1-1:0]     w_burst, w_burst_next, w_beats, w_beat_inc;
  logic [DATA_W-1:0]  w_wdata, w_data_next, w_tx_word, w_tx_next;
  logic w_addr_bit, w_burst_bit, w_burst_last, w_data_bit;
  logic w_last_beat, w_wr_boundary, w_cap_boundary, w_split_done;
  logic [DELAY_W-1:0] w_split_len;
  logic w_unused_bits;

  assign w_run       = ~reset;
  assign w_start     = (r_state == ST_IDLE) && m_valid && (read_enable ^ write_enable);
  assign w_hdr_shift = w_start || ((r_state == ST_HDR) && m_valid);
  assign w_wd_shift  = (r_state == ST_WDATA) && m_valid;
  assign w_tx_shift  = (r_state == ST_TX) && m_ready;

  serial_shifter_p #(.W(HDR_LEN)) u_rx_addr (
    .clk(clk), .reset(reset), .i_clear(w_start), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_hdr_shift), .i_bit(rx_address), .o_data(w_addr_data),
    .o_data_next(w_addr_next), .o_bit(w_addr_bit), .o_last(w_addr_last)
  );

  // Only the first BURST_W+1 header bits are kept; the shifter saturates after that.
  serial_shifter_p #(.W(BW1)) u_rx_burst (
    .clk(clk), .reset(reset), .i_clear(w_start), .i_load(1'b0), .i_load_data('0),
    .i_shift(w_hdr_shift), .i_bit(rx_burst), .o_data(w_burst),
    .o_data_next(w_burst_next), .o_bit(w_burst_bit), .o_last(w_burst_last)
  );

  serial_shifter_p #(.W(DATA_W)) u_rx_data (
    .clk(clk), .reset(reset), .i_clear(w_start || (r_state == ST_WRITE)), .i_load(1'b0),
    .i_load_data('0), .i_shift(w_wd_shift), .i_bit(rx_data), .o_data(w_wdata),
    .o_data_next(w_data_next), .o_bit(w_data_bit), .o_last(w_data_last)
  );

  serial_shifter_p #(.W(DATA_W)) u_tx_data (
    .clk(clk), .reset(reset), .i_clear(1'b0), .i_load(r_state == ST_RD_CAP),
    .i_load_data(mem_rdata), .i_shift(w_tx_shift), .i_bit(1'b0), .o_data(w_tx_word),
    .o_data_next(w_tx_next), .o_bit(w_tx_bit), .o_last(w_tx_last)
  );

  assign w_unused_bits = ^{w_addr_data, w_addr_bit, w_burst_next, w_burst_bit, w_burst_last,
                           w_data_next, w_data_bit, w_tx_word, w_tx_next};

  assign w_beats        = w_burst[0] ? (BW1'(w_burst[BW1-1:1]) + BW1'(1)) : BW1'(1);
  assign w_beat_inc     = r_beat_cnt + BW1'(1);
  assign w_last_beat    = (w_beat_inc == w_beats);
  assign w_wr_boundary  = ((w_beat_inc % SPLIT_C) == '0);
  assign w_cap_boundary = (r_beat_cnt != '0) && ((r_beat_cnt % SPLIT_C) == '0);
  assign w_split_len    = (slave_delay == '0) ? DELAY_W'(1) : slave_delay;
  assign w_split_done   = (r_split_cnt == w_split_len - DELAY_W'(1));

  always_comb begin
    w_state_next = r_state;
    s_ready      = 1'b0;
    s_valid      = 1'b0;
    tx_data      = 1'b0;
    split_enable = 1'b0;
    mem_wr       = 1'b0;
    mem_rd       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        s_ready = w_run;
        if (w_start) w_state_next = ST_HDR;
      end
      ST_HDR: begin
        s_ready = w_run;
        if (w_addr_last) w_state_next = r_is_read ? ST_RD_REQ : ST_WDATA;
      end
      ST_WDATA: begin
        s_ready = w_run;
        if (w_data_last) w_state_next = ST_WRITE;
      end
      ST_WRITE: begin
        mem_wr = w_run;
        if (w_last_beat)        w_state_next = ST_IDLE;
        else if (w_wr_boundary) w_state_next = ST_SPLIT;
        else                    w_state_next = ST_WDATA;
      end
      ST_RD_REQ: begin
        mem_rd       = w_run;
        w_state_next = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        if ((r_beat_cnt == '0) && (slave_delay >= THRESH_C)) w_state_next = ST_SPLIT;
        else if (w_cap_boundary)                              w_state_next = ST_SPLIT;
        else                                                  w_state_next = ST_TX;
      end
      ST_SPLIT: begin
        split_enable = w_run;
        if (w_split_done) w_state_next = r_is_read ? ST_TX : ST_WDATA;
      end
      ST_TX: begin
        s_valid = w_run;
        tx_data = w_run & w_tx_bit;
        if (w_tx_last) w_state_next = w_last_beat ? ST_IDLE : ST_RD_REQ;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign mem_addr  = r_addr  & {ADDR_W{w_run}};
  assign mem_wdata = w_wdata & {DATA_W{w_run}};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_beat_cnt  <= '0;
      r_split_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_is_read  <= read_enable;
        r_beat_cnt <= '0;
      end
      // The address shifter's next value already includes this cycle's last header bit.
      if ((r_state == ST_HDR) && w_addr_last) r_addr <= w_addr_next[ADDR_W-1:0];
      if ((r_state == ST_WRITE) || w_tx_last) begin
        r_addr     <= r_addr + ADDR_W'(1);
        r_beat_cnt <= w_beat_inc;
      end
      r_split_cnt <= ((r_state == ST_SPLIT) && !w_split_done) ? r_split_cnt + DELAY_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_serial_slave_port_p.sv
// Scoreboard bench: stimulus pushes expected writes, read bytes and split lengths;
// a negedge monitor pops and compares whenever the port presents them.
module tb_serial_slave_port_p;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] slave_delay = 6'd2;
  logic       read_enable = 1'b0, write_enable = 1'b0, m_valid = 1'b0, m_ready = 1'b1;
  logic       rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
  logic       s_ready, s_valid, tx_data, split_enable, mem_wr, mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  typedef struct packed { logic [11:0] a; logic [7:0] d; } wr_t;

  logic [7:0] tb_mem [0:4095];
  wr_t        exp_wr_q[$];
  logic [7:0] exp_tx_q[$];
  int         exp_split_q[$];
  wr_t        mon_e;
  logic [7:0] tx_shift = 8'h00;
  int n_tests = 0, n_fail = 0;
  int tx_bits = 0, tx_bytes = 0, rd_cnt = 0, split_run = 0;
  bit stall_rd = 1'b0;

  serial_slave_port_p dut (
    .clk(clk), .reset(reset), .slave_delay(slave_delay), .read_enable(read_enable),
    .write_enable(write_enable), .m_valid(m_valid), .m_ready(m_ready),
    .rx_address(rx_address), .rx_burst(rx_burst), .rx_data(rx_data),
    .s_ready(s_ready), .s_valid(s_valid), .tx_data(tx_data), .split_enable(split_enable),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= tb_mem[mem_addr];

  initial forever begin
    @(posedge clk); #1;
    m_ready = stall_rd ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic int split_len(input int d);
    return (d < 1) ? 1 : d;
  endfunction

  // Monitor: everything is sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      tx_bits   = 0;
      split_run = 0;
    end else begin
      if (mem_rd) rd_cnt++;
      if (mem_wr) begin
        if (exp_wr_q.size() == 0) fail_now("unexpected_mem_wr");
        else begin
          mon_e = exp_wr_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e.a));
          check("wr_data", 32'(mem_wdata), 32'(mon_e.d));
        end
      end
      if (s_valid && m_ready) begin
        tx_shift = {tx_data, tx_shift[7:1]};
        tx_bits++;
        if (tx_bits == 8) begin
          tx_bits = 0;
          tx_bytes++;
          if (exp_tx_q.size() == 0) fail_now("unexpected_tx_byte");
          else check("tx_byte", 32'(tx_shift), 32'(exp_tx_q.pop_front()));
        end
      end
      if (split_enable) split_run++;
      else if (split_run != 0) begin
        if (exp_split_q.size() == 0) fail_now("unexpected_split");
        else check("split_len", 32'(split_run), 32'(exp_split_q.pop_front()));
        split_run = 0;
      end
    end
  end

  task automatic send_bit(input logic a, input logic b, input logic d, input bit stall);
    bit ok;
    int guard;
    if (stall && ($urandom_range(0, 2) == 0)) begin
      m_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    m_valid = 1'b1; rx_address = a; rx_burst = b; rx_data = d;
    ok = 1'b0; guard = 0;
    while (!ok && guard < 300) begin
      @(negedge clk); ok = s_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) fail_now("handshake_timeout");
  endtask

  task automatic send_header(input logic rd, input logic [11:0] addr, input logic [11:0] hdr,
                             input bit stall);
    read_enable = rd; write_enable = ~rd;
    for (int i = 0; i < 12; i++) send_bit(addr[i], hdr[i], 1'b0, stall);
    read_enable = 1'b0; write_enable = 1'b0;
  endtask

  function automatic logic [11:0] burst_hdr(input int nbeats);
    return (nbeats > 1) ? 12'(((nbeats - 1) << 1) | 1) : 12'h000;
  endfunction

  task automatic wait_done(input string name);
    int guard = 0;
    while (!(exp_wr_q.size() == 0 && exp_tx_q.size() == 0 && s_ready) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check({name, "_completes"}, 32'(guard < 3000), 32'd1);
    check({name, "_splits_seen"}, 32'(exp_split_q.size()), 32'd0);
    exp_wr_q.delete(); exp_tx_q.delete(); exp_split_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic write_txn(input string name, input logic [11:0] addr, input int nbeats,
                           input logic [7:0] base, input bit stall);
    logic [7:0] d;
    for (int k = 0; k < nbeats; k++) exp_wr_q.push_back('{a: 12'(addr + k), d: 8'(base + k)});
    for (int k = 1; k < nbeats; k++)
      if (k % 8 == 0) exp_split_q.push_back(split_len(int'(slave_delay)));
    send_header(1'b0, addr, burst_hdr(nbeats), stall);
    for (int k = 0; k < nbeats; k++) begin
      d = 8'(base + k);
      for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b0, d[i], stall);
    end
    m_valid = 1'b0;
    wait_done(name);
  endtask

  task automatic read_txn(input string name, input logic [11:0] addr, input int nbeats,
                          input bit stall);
    for (int k = 0; k < nbeats; k++) exp_tx_q.push_back(tb_mem[12'(addr + k)]);
    if (int'(slave_delay) >= 5) exp_split_q.push_back(split_len(int'(slave_delay)));
    for (int k = 1; k < nbeats; k++)
      if (k % 8 == 0) exp_split_q.push_back(split_len(int'(slave_delay)));
    stall_rd = stall;
    send_header(1'b1, addr, burst_hdr(nbeats), stall);
    m_valid = 1'b0;
    wait_done(name);
    stall_rd = 1'b0;
  endtask

  initial begin
    int guard;
    int rd_before;
    int base_bytes;
    for (int i = 0; i < 4096; i++) tb_mem[i] = 8'h00;
    tb_mem[12'h010] = 8'hA7; tb_mem[12'h020] = 8'h5A;
    tb_mem[12'h040] = 8'hC3; tb_mem[12'h041] = 8'h1E; tb_mem[12'h042] = 8'hF0;
    tb_mem[12'h050] = 8'h11; tb_mem[12'h051] = 8'h22; tb_mem[12'h052] = 8'h33;
    tb_mem[12'h053] = 8'h44; tb_mem[12'h054] = 8'h55;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({s_ready, s_valid, tx_data, split_enable, mem_addr, mem_wdata,
                                mem_wr, mem_rd}), 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    check("s_ready_after_release", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    slave_delay = 6'd2;
    write_txn("wr_single", 12'h0A5, 1, 8'h3C, 1'b0);
    read_txn("rd_single", 12'h010, 1, 1'b0);

    slave_delay = 6'd7;
    read_txn("rd_split7", 12'h020, 1, 1'b0);

    slave_delay = 6'd3;
    write_txn("wr_burst10_wrap", 12'hFFE, 10, 8'h10, 1'b0);

    slave_delay = 6'd2;
    write_txn("wr_burst3", 12'h123, 3, 8'h40, 1'b0);
    write_txn("wr_burst3_stall", 12'h123, 3, 8'h40, 1'b1);
    read_txn("rd_burst3", 12'h040, 3, 1'b0);
    read_txn("rd_burst3_stall", 12'h040, 3, 1'b1);

    // Reset during the third beat of a five-beat read.
    slave_delay = 6'd1;
    exp_tx_q.push_back(tb_mem[12'h050]);
    exp_tx_q.push_back(tb_mem[12'h051]);
    base_bytes = tx_bytes;
    send_header(1'b1, 12'h050, burst_hdr(5), 1'b0);
    m_valid = 1'b0;
    guard = 0;
    while (!(tx_bytes == base_bytes + 2 && s_valid) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("rst_reach_beat3", 32'(guard < 500), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    rd_before = rd_cnt;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_outputs", 32'({s_ready, s_valid, tx_data, split_enable, mem_addr, mem_wdata,
                                  mem_wr, mem_rd}), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_s_ready", 32'(s_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("rst_no_more_mem_rd", 32'(rd_cnt), 32'(rd_before));
    check("rst_tx_bytes_before", 32'(exp_tx_q.size()), 32'd0);
    exp_tx_q.delete();
    @(posedge clk); #1;
    write_txn("wr_after_reset", 12'h300, 1, 8'h99, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
